// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- decode-stage immediate generator with a 2-entry skid buffer.
//
// Decodes the RV32I/RV64I immediate formats (R/I/S/B/U/J) from a raw
// instruction word. It sign-extends the immediate to XLEN, flags unsupported
// opcodes, and keeps a saturating count of illegal words delivered downstream.
// A valid/ready skid buffer (main + skid entry) sits between fetch and ID/EX.
//
// Parameters:
//   XLEN   32 or 64, immediate width
//   CNT_W  width of the saturating illegal-instruction counter
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous flush; empties the buffer, drops same-cycle traffic
//   in_valid     in   instruction valid
//   in_ready     out  block can accept (registered)
//   instruction  in   raw 32-bit instruction word
//   out_valid    out  outputs valid
//   out_ready    in   downstream accepts
//   instr_out    out  instruction passed through with its immediate
//   imm_value    out  sign-extended immediate
//   imm_fmt      out  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   imm_illegal  out  opcode unsupported
//   illegal_cnt  out  saturating count of illegal words delivered

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic [XLEN-1:0]  imm_value,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state;
    entry_t dec, main_q, skid_q;
    logic   accept, deliver;

    // Every format is first assembled as a 32-bit signed value, then widened.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    // ---------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        dec.instr = instruction;
        dec.imm   = '0;
        dec.fmt   = FMT_ILL;
        dec.ill   = 1'b0;
        case (opcode)
            7'b0110011: dec.fmt = FMT_R;
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt = FMT_I;
                dec.imm = sext32({{20{instruction[31]}}, instruction[31:20]});
            end
            7'b0010011: begin
                dec.fmt = FMT_I;
                // Shift amount only; funct7 (arith/logic select) is not part of the immediate.
                if (is_shift)
                    dec.imm = IS64 ? XLEN'(instruction[25:20]) : XLEN'(instruction[24:20]);
                else
                    dec.imm = sext32({{20{instruction[31]}}, instruction[31:20]});
            end
            7'b0011011: begin
                // OP-IMM-32: word shifts always use a 5-bit shamt
                if (IS64) begin
                    dec.fmt = FMT_I;
                    if (is_shift)
                        dec.imm = XLEN'(instruction[24:20]);
                    else
                        dec.imm = sext32({{20{instruction[31]}}, instruction[31:20]});
                end else begin
                    dec.ill = 1'b1;
                end
            end
            7'b0111011: begin
                if (IS64) dec.fmt = FMT_R;
                else      dec.ill = 1'b1;
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = sext32({{20{instruction[31]}}, instruction[31:25], instruction[11:7]});
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = sext32({{19{instruction[31]}}, instruction[31], instruction[7],
                                  instruction[30:25], instruction[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = sext32({instruction[31:12], 12'b0});
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = sext32({{11{instruction[31]}}, instruction[31], instruction[19:12],
                                  instruction[20], instruction[30:21], 1'b0});
            end
            default: dec.ill = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // Skid buffer FSM; main entry drives the outputs directly
    // ---------------------------------------------------------------
    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            main_q      <= '0;
            skid_q      <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            // Stale entry data is left in place; out_valid=0 masks it.
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (deliver && main_q.ill && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= dec;
                        state     <= ONE;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !deliver) begin
                        skid_q   <= dec;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (deliver && !accept) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else if (accept && deliver) begin
                        main_q <= dec;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide
                    if (deliver) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign instr_out   = main_q.instr;
    assign imm_value   = main_q.imm;
    assign imm_fmt     = main_q.fmt;
    assign imm_illegal = main_q.ill;

endmodule
